// File: rtl/bp_cce_fill_sender_pkg.sv
// Shared BedRock LCE fill/resp message types and processor-config widths for the CCE fill sender.
package bp_cce_fill_sender_pkg;

  localparam int unsigned paddr_width_gp     = 40;
  localparam int unsigned lce_id_width_gp    = 4;
  localparam int unsigned cce_id_width_gp    = 4;
  localparam int unsigned lce_assoc_gp       = 8;
  localparam int unsigned lce_assoc_width_gp = $clog2(lce_assoc_gp);

  typedef enum logic [2:0] {
    e_COH_I = 3'd0,
    e_COH_S = 3'd1,
    e_COH_E = 3'd2,
    e_COH_F = 3'd3,
    e_COH_M = 3'd6,
    e_COH_O = 3'd7
  } bp_coh_states_e;

  typedef enum logic [3:0] {
    e_bedrock_fill_normal = 4'd0,
    e_bedrock_fill_data   = 4'd1,
    e_bedrock_fill_inv    = 4'd2
  } bp_bedrock_fill_type_e;

  typedef enum logic [3:0] {
    e_bedrock_resp_sync    = 4'd0,
    e_bedrock_resp_inv_ack = 4'd1,
    e_bedrock_resp_coh_ack = 4'd2,
    e_bedrock_resp_wb      = 4'd3,
    e_bedrock_resp_null_wb = 4'd4
  } bp_bedrock_resp_type_e;

  // Encoded as log2(bytes)
  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [lce_id_width_gp-1:0]    dst_id;
    logic [cce_id_width_gp-1:0]    src_id;
    logic [lce_assoc_width_gp-1:0] way_id;
    bp_coh_states_e                state;
  } bp_bedrock_fill_payload_s;

  typedef struct packed {
    bp_bedrock_fill_payload_s    payload;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_fill_type_e       msg_type;
  } bp_bedrock_fill_header_s;

  typedef struct packed {
    logic [cce_id_width_gp-1:0] dst_id;
    logic [lce_id_width_gp-1:0] src_id;
  } bp_bedrock_resp_payload_s;

  typedef struct packed {
    bp_bedrock_resp_payload_s    payload;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_resp_type_e       msg_type;
  } bp_bedrock_resp_header_s;

  function automatic int unsigned safe_clog2(input int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bp_cce_fill_sender_wrap.sv
// Beat counter for a wraparound burst: full_o counts beats sent, wrap_o is the block-relative index.
module bp_cce_fill_sender_wrap
  import bp_cce_fill_sender_pkg::*;
  #(parameter int unsigned max_val_p = 7,
    parameter int unsigned width_p   = safe_clog2(max_val_p + 1))
  (input  logic               clk_i,
   input  logic               reset_i,
   input  logic [width_p-1:0] size_i,
   input  logic               set_i,
   input  logic [width_p-1:0] val_i,
   input  logic               en_i,
   output logic [width_p-1:0] wrap_o,
   output logic [width_p-1:0] full_o);

  logic [width_p-1:0] base_q, base_d;
  logic [width_p-1:0] cnt_q, cnt_d;

  always_comb begin
    base_d = base_q;
    cnt_d  = cnt_q;
    if (set_i) begin
      base_d = val_i;
      cnt_d  = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + width_p'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      base_q <= '0;
      cnt_q  <= '0;
    end else begin
      base_q <= base_d;
      cnt_q  <= cnt_d;
    end
  end

  // Bits above size_i stay fixed; bits inside wrap modulo the burst length
  assign wrap_o = (base_q & ~size_i) | ((base_q + cnt_q) & size_i);
  assign full_o = cnt_q;

endmodule

// File: rtl/bp_cce_fill_sender.sv
// CCE-side LCE fill transmitter: header, wraparound data burst, then wait for the LCE coh_ack.
// Optional build macro BP_CCE_FILL_ACK_CHECK_EN: only acks matching the latched LCE and block complete.
module bp_cce_fill_sender
  import bp_cce_fill_sender_pkg::*;
  #(parameter int unsigned block_width_p = 512,
    parameter int unsigned fill_width_p  = 64)
  (input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [cce_id_width_gp-1:0]    cce_id_i,
   input  logic                          fill_v_i,
   output logic                          fill_ready_and_o,
   input  logic [paddr_width_gp-1:0]     fill_addr_i,
   input  logic [lce_id_width_gp-1:0]    fill_lce_id_i,
   input  logic [lce_assoc_width_gp-1:0] fill_way_id_i,
   input  bp_coh_states_e                fill_state_i,
   input  logic [block_width_p-1:0]      fill_data_i,
   output bp_bedrock_fill_header_s       lce_fill_header_o,
   output logic                          lce_fill_header_v_o,
   input  logic                          lce_fill_header_ready_and_i,
   output logic                          lce_fill_has_data_o,
   output logic [fill_width_p-1:0]       lce_fill_data_o,
   output logic                          lce_fill_data_v_o,
   input  logic                          lce_fill_data_ready_and_i,
   output logic                          lce_fill_last_o,
   input  bp_bedrock_resp_header_s       lce_resp_header_i,
   input  logic                          lce_resp_header_v_i,
   output logic                          lce_resp_header_ready_and_o,
   output logic                          fill_done_o,
   output logic                          ack_error_o);

  localparam int unsigned fill_bytes_lp         = fill_width_p / 8;
  localparam int unsigned block_size_in_fill_lp = block_width_p / fill_width_p;
  localparam int unsigned fill_select_width_lp  = safe_clog2(block_size_in_fill_lp);
  localparam int unsigned fill_offset_lp        = $clog2(fill_bytes_lp);
  localparam int unsigned block_offset_lp       = $clog2(block_width_p / 8);
  localparam logic [fill_select_width_lp-1:0] last_cnt_lp =
    fill_select_width_lp'(block_size_in_fill_lp - 1);

  typedef enum logic [1:0] {e_ready, e_header, e_data, e_wait_ack} state_e;

  state_e                                              state_q, state_d;
  logic [paddr_width_gp-1:0]                           addr_q, addr_d;
  logic [lce_id_width_gp-1:0]                          lce_q, lce_d;
  logic [lce_assoc_width_gp-1:0]                       way_q, way_d;
  bp_coh_states_e                                      coh_q, coh_d;
  logic [block_size_in_fill_lp-1:0][fill_width_p-1:0]  data_q, data_d;

  logic                            cnt_set, cnt_en;
  logic [fill_select_width_lp-1:0] first_c, wrap_cnt, full_cnt;
  logic                            ack_c, ack_match_c;
  logic                            resp_unused;

  assign first_c = (block_size_in_fill_lp > 1)
                 ? fill_addr_i[fill_offset_lp +: fill_select_width_lp] : '0;
  assign ack_c   = lce_resp_header_v_i && (lce_resp_header_i.msg_type == e_bedrock_resp_coh_ack);
  assign resp_unused = ^lce_resp_header_i;

`ifdef BP_CCE_FILL_ACK_CHECK_EN
  logic err_q, err_d;
  assign ack_match_c = (lce_resp_header_i.payload.src_id == lce_q)
    && (lce_resp_header_i.addr[paddr_width_gp-1:block_offset_lp] == addr_q[paddr_width_gp-1:block_offset_lp]);
  assign ack_error_o = err_q;
`else
  assign ack_match_c = 1'b1;
  assign ack_error_o = 1'b0;
`endif

  bp_cce_fill_sender_wrap
    #(.max_val_p(block_size_in_fill_lp - 1), .width_p(fill_select_width_lp))
    u_wrap
     (.clk_i   (clk_i),
      .reset_i (reset_i),
      .size_i  (last_cnt_lp),
      .set_i   (cnt_set),
      .val_i   (first_c),
      .en_i    (cnt_en),
      .wrap_o  (wrap_cnt),
      .full_o  (full_cnt));

  // Next-state and Moore outputs; fill_done_o is the only output qualified by an inbound valid
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lce_d   = lce_q;
    way_d   = way_q;
    coh_d   = coh_q;
    data_d  = data_q;
`ifdef BP_CCE_FILL_ACK_CHECK_EN
    err_d   = err_q;
`endif
    cnt_set                     = 1'b0;
    cnt_en                      = 1'b0;
    fill_ready_and_o            = 1'b0;
    lce_fill_header_v_o         = 1'b0;
    lce_fill_data_v_o           = 1'b0;
    lce_resp_header_ready_and_o = 1'b0;
    fill_done_o                 = 1'b0;

    case (state_q)
      e_ready: begin
        fill_ready_and_o = 1'b1;
        if (fill_v_i) begin
          addr_d  = fill_addr_i;
          lce_d   = fill_lce_id_i;
          way_d   = fill_way_id_i;
          coh_d   = fill_state_i;
          data_d  = fill_data_i;
          cnt_set = 1'b1;
          state_d = e_header;
        end
      end
      e_header: begin
        lce_fill_header_v_o = 1'b1;
        if (lce_fill_header_ready_and_i) state_d = e_data;
      end
      e_data: begin
        lce_fill_data_v_o = 1'b1;
        if (lce_fill_data_ready_and_i) begin
          cnt_en = 1'b1;
          if (full_cnt == last_cnt_lp) state_d = e_wait_ack;
        end
      end
      e_wait_ack: begin
        lce_resp_header_ready_and_o = 1'b1;
        if (ack_c) begin
          if (ack_match_c) begin
            fill_done_o = 1'b1;
            state_d     = e_ready;
          end
`ifdef BP_CCE_FILL_ACK_CHECK_EN
          else begin
            err_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = e_ready;
    endcase

    lce_fill_header_o                = '0;
    lce_fill_header_o.msg_type       = e_bedrock_fill_data;
    lce_fill_header_o.addr           = addr_q;
    lce_fill_header_o.size           = bp_bedrock_msg_size_e'(3'(block_offset_lp));
    lce_fill_header_o.payload.dst_id = lce_q;
    lce_fill_header_o.payload.src_id = cce_id_i;
    lce_fill_header_o.payload.way_id = way_q;
    lce_fill_header_o.payload.state  = coh_q;
    lce_fill_has_data_o              = lce_fill_header_v_o;
    lce_fill_data_o                  = data_q[wrap_cnt];
    lce_fill_last_o                  = (state_q == e_data) && (full_cnt == last_cnt_lp);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_ready;
      addr_q  <= '0;
      lce_q   <= '0;
      way_q   <= '0;
      coh_q   <= e_COH_I;
      data_q  <= '0;
`ifdef BP_CCE_FILL_ACK_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lce_q   <= lce_d;
      way_q   <= way_d;
      coh_q   <= coh_d;
      data_q  <= data_d;
`ifdef BP_CCE_FILL_ACK_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_bp_cce_fill_sender.sv
// Self-checking bench for bp_cce_fill_sender (512-bit block, 64-bit beats) with a transaction-level model.
`timescale 1ns/1ps
module tb_bp_cce_fill_sender;
  import bp_cce_fill_sender_pkg::*;

  localparam int unsigned BW = 512;
  localparam int unsigned FW = 64;
  localparam int unsigned NB = BW / FW;

  logic                          clk;
  logic                          rst;
  logic [cce_id_width_gp-1:0]    cce_id;
  logic                          fill_v, fill_ready;
  logic [paddr_width_gp-1:0]     fill_addr;
  logic [lce_id_width_gp-1:0]    fill_lce;
  logic [lce_assoc_width_gp-1:0] fill_way;
  bp_coh_states_e                fill_state;
  logic [BW-1:0]                 fill_data;
  bp_bedrock_fill_header_s       hdr;
  logic                          hdr_v, hdr_ready, has_data;
  logic [FW-1:0]                 data;
  logic                          data_v, data_ready, last;
  bp_bedrock_resp_header_s       resp;
  logic                          resp_v, resp_ready, done, ack_err;

  bp_cce_fill_sender #(.block_width_p(BW), .fill_width_p(FW)) dut
    (.clk_i(clk), .reset_i(rst), .cce_id_i(cce_id),
     .fill_v_i(fill_v), .fill_ready_and_o(fill_ready), .fill_addr_i(fill_addr),
     .fill_lce_id_i(fill_lce), .fill_way_id_i(fill_way), .fill_state_i(fill_state),
     .fill_data_i(fill_data),
     .lce_fill_header_o(hdr), .lce_fill_header_v_o(hdr_v),
     .lce_fill_header_ready_and_i(hdr_ready), .lce_fill_has_data_o(has_data),
     .lce_fill_data_o(data), .lce_fill_data_v_o(data_v),
     .lce_fill_data_ready_and_i(data_ready), .lce_fill_last_o(last),
     .lce_resp_header_i(resp), .lce_resp_header_v_i(resp_v),
     .lce_resp_header_ready_and_o(resp_ready),
     .fill_done_o(done), .ack_error_o(ack_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  bit                      m_busy, m_hdr, m_ack, m_err;
  logic [FW-1:0]           m_q[$];
  bp_bedrock_fill_header_s m_hdr_exp;
  logic [lce_id_width_gp-1:0] m_lce;
  logic [paddr_width_gp-1:0]  m_addr;
  int                      m_beats, cyc, acc_cyc, hdr_cyc, last_cyc, done_cnt;
  logic [2:0]              hdr_size_seen;
  logic [FW-1:0]           beat_log[$];
  logic                    cmp_dv, cmp_ack, cmp_mism;

  // Bench-side control of the sink readies
  bit hdr_en, thr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    hdr_ready  = hdr_en;
    data_ready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare every cycle, then advance the model by the handshakes the next edge will take
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 0; m_hdr = 0; m_ack = 0; m_err = 0;
      m_q.delete();
    end
    chk("fill_ready", 64'(fill_ready), 64'(!m_busy));
    chk("hdr_v", 64'(hdr_v), 64'(m_hdr));
    if (m_hdr) begin
      chk("hdr", 64'(hdr), 64'(m_hdr_exp));
      chk("has_data", 64'(has_data), 64'd1);
      hdr_size_seen = hdr.size;
    end
    cmp_dv = m_busy && !m_hdr && (m_q.size() > 0);
    chk("data_v", 64'(data_v), 64'(cmp_dv));
    if (cmp_dv) begin
      chk("data", data, m_q[0]);
      chk("last", 64'(last), 64'(m_q.size() == 1));
    end
    chk("resp_ready", 64'(resp_ready), 64'(m_ack));
    cmp_ack = m_ack && resp_v && (resp.msg_type == e_bedrock_resp_coh_ack);
`ifdef BP_CCE_FILL_ACK_CHECK_EN
    cmp_mism = cmp_ack && ((resp.payload.src_id != m_lce) || ((resp.addr >> 6) != (m_addr >> 6)));
`else
    cmp_mism = 1'b0;
`endif
    chk("done", 64'(done), 64'(cmp_ack && !cmp_mism));
    chk("ack_error", 64'(ack_err), 64'(m_err));
    if (done) done_cnt++;

    if (!rst) begin
      if (!m_busy && fill_v) begin
        m_busy = 1; m_hdr = 1; acc_cyc = cyc;
        m_lce = fill_lce; m_addr = fill_addr;
        m_hdr_exp = '0;
        m_hdr_exp.msg_type = e_bedrock_fill_data;
        m_hdr_exp.addr = fill_addr;
        m_hdr_exp.size = e_bedrock_msg_size_64;
        m_hdr_exp.payload.dst_id = fill_lce;
        m_hdr_exp.payload.src_id = cce_id;
        m_hdr_exp.payload.way_id = fill_way;
        m_hdr_exp.payload.state  = fill_state;
        for (int k = 0; k < NB; k++) begin
          int idx;
          idx = (int'((fill_addr / 8) % NB) + k) % NB;
          m_q.push_back(fill_data[idx*FW +: FW]);
        end
      end else if (m_hdr && hdr_ready) begin
        m_hdr = 0; hdr_cyc = cyc;
      end else if (cmp_dv && data_ready) begin
        beat_log.push_back(m_q[0]);
        void'(m_q.pop_front());
        m_beats++;
        if (m_q.size() == 0) begin m_ack = 1; last_cyc = cyc; end
      end else if (cmp_ack) begin
        if (cmp_mism) m_err = 1;
        else begin m_ack = 0; m_busy = 0; end
      end
    end
  end

  task automatic send_fill(input logic [paddr_width_gp-1:0] a, input logic [lce_id_width_gp-1:0] l,
                           input logic [lce_assoc_width_gp-1:0] w, input bp_coh_states_e s,
                           input logic [BW-1:0] d);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    fill_v = 1; fill_addr = a; fill_lce = l; fill_way = w; fill_state = s; fill_data = d;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (fill_ready) ok = 1;
    end
    if (!ok) chk("fill_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    fill_v = 0;
  endtask

  task automatic send_resp(input bp_bedrock_resp_type_e ty, input logic [lce_id_width_gp-1:0] src,
                           input logic [paddr_width_gp-1:0] a);
    bit ok;
    ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (resp_ready) ok = 1;
    end
    if (!ok) chk("resp_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    resp_v = 1;
    resp = '0;
    resp.msg_type = ty;
    resp.addr = a;
    resp.payload.src_id = src;
    resp.payload.dst_id = cce_id;
    @(negedge clk);
    @(posedge clk); #1;
    resp_v = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  logic [BW-1:0] blk;
  int            d0, idx_exp[8];

  initial begin
    rst = 1; fill_v = 0; resp_v = 0; resp = '0; cce_id = 4'd9;
    fill_addr = '0; fill_lce = '0; fill_way = '0; fill_state = e_COH_I; fill_data = '0;
    hdr_en = 1; thr = 0; hdr_ready = 1; data_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_fill_ready", 64'(fill_ready), 64'd1);
    chk("reset_hdr_v", 64'(hdr_v), 64'd0);
    rst = 0;

    // 1: critical fill 5, all readies high
    for (int i = 0; i < NB; i++) blk[i*FW +: FW] = {8{8'(i * 17)}};
    beat_log.delete(); done_cnt = 0;
    send_fill(40'h80_0000_0128, 4'd3, 3'd2, e_COH_M, blk);
    send_resp(e_bedrock_resp_coh_ack, 4'd3, 40'h80_0000_0100);
    repeat (2) @(negedge clk);
    chk("t1_hdr_latency", 64'(hdr_cyc - acc_cyc), 64'd1);
    chk("t1_last_latency", 64'(last_cyc - acc_cyc), 64'd9);
    chk("t1_size", 64'(hdr_size_seen), 64'd6);
    chk("t1_nbeats", 64'(beat_log.size()), 64'd8);
    idx_exp = '{5, 6, 7, 0, 1, 2, 3, 4};
    for (int k = 0; k < 8 && k < beat_log.size(); k++)
      chk($sformatf("t1_beat%0d", k), beat_log[k], {8{8'(idx_exp[k] * 17)}});
    chk("t1_beat0_lit", beat_log[0], 64'h5555_5555_5555_5555);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk("t1_back_ready", 64'(fill_ready), 64'd1);

    // 2: aligned address, throttled data ready
    for (int i = 0; i < NB; i++) blk[i*FW +: FW] = {$urandom, $urandom};
    beat_log.delete(); thr = 1;
    send_fill(40'h80_0000_0100, 4'd1, 3'd5, e_COH_S, blk);
    send_resp(e_bedrock_resp_coh_ack, 4'd1, 40'h80_0000_0100);
    thr = 0;
    chk("t2_nbeats", 64'(beat_log.size()), 64'd8);
    for (int k = 0; k < 8 && k < beat_log.size(); k++)
      chk($sformatf("t2_beat%0d", k), beat_log[k], blk[k*FW +: FW]);

    // 3: header stalled for 10 cycles
    hdr_en = 0;
    send_fill(40'h80_0000_0240, 4'd7, 3'd0, e_COH_E, blk);
    repeat (10) @(negedge clk);
    #1;
    chk("t3_hdr_held", 64'(hdr_v), 64'd1);
    chk("t3_no_data", 64'(data_v), 64'd0);
    chk("t3_no_accept", 64'(fill_ready), 64'd0);
    hdr_en = 1;

    // 4: sync response ignored, then ack completes
    d0 = done_cnt;
    send_resp(e_bedrock_resp_sync, 4'd7, 40'h80_0000_0240);
    repeat (2) @(negedge clk);
    chk("t4_sync_no_done", 64'(done_cnt), 64'(d0));
    send_resp(e_bedrock_resp_coh_ack, 4'd7, 40'h80_0000_0240);
    chk("t4_ack_done", 64'(done_cnt), 64'(d0 + 1));

    // 5: ack from the wrong LCE
    send_fill(40'h80_0000_0300, 4'd4, 3'd1, e_COH_S, blk);
    d0 = done_cnt;
    send_resp(e_bedrock_resp_coh_ack, 4'd5, 40'h80_0000_0300);
`ifdef BP_CCE_FILL_ACK_CHECK_EN
    #1;
    chk("t5_err_set", 64'(ack_err), 64'd1);
    chk("t5_no_done", 64'(done_cnt), 64'(d0));
    send_resp(e_bedrock_resp_coh_ack, 4'd4, 40'h80_0000_0300);
    #1;
    chk("t5_done", 64'(done_cnt), 64'(d0 + 1));
    chk("t5_err_sticky", 64'(ack_err), 64'd1);
`else
    #1;
    chk("t5_done_any_ack", 64'(done_cnt), 64'(d0 + 1));
    chk("t5_err_tied0", 64'(ack_err), 64'd0);
`endif

    // 6: asynchronous reset after the third beat, then a clean transaction
    d0 = m_beats;
    send_fill(40'h80_0000_0400, 4'd2, 3'd3, e_COH_M, blk);
    begin
      bit ok;
      ok = 0;
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge clk); #1;
        if (m_beats >= d0 + 3) ok = 1;
      end
      if (!ok) chk("t6_beat_timeout", 64'd0, 64'd1);
    end
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("t6_rst_data_v", 64'(data_v), 64'd0);
    chk("t6_rst_hdr_v", 64'(hdr_v), 64'd0);
    chk("t6_rst_ready", 64'(fill_ready), 64'd1);
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_err", 64'(ack_err), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    d0 = done_cnt;
    send_fill(40'h80_0000_0418, 4'd6, 3'd4, e_COH_E, blk);
    send_resp(e_bedrock_resp_coh_ack, 4'd6, 40'h80_0000_0400);
    #1;
    chk("t6_fresh_done", 64'(done_cnt), 64'(d0 + 1));
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
